runner_cmd_ctrl: RTL and testbench

- Consumes the one-cycle debounced button pulses (left, right, jump, slide) produced by the button debounce stage.
- Buffers them in a small command FIFO and applies them to the player at frame rate.
- Outputs the player lane, pose and jump height to the renderer and collision logic.
- Sits between the debounce stage and the game-state/render pipeline.

---
 rtl/runner_cmd_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_runner_cmd_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/runner_cmd_ctrl.sv
// Purpose: turns debounced button pulses into queued player commands and applies them at frame rate.
// Latency: a pulse reaches the FIFO head one cycle later; the head is applied on the next qualifying frame tick.
// Backpressure: none upstream. Pushes into a full FIFO with no pop that cycle are dropped (and counted when enabled).
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   btn[3:0]          one-cycle pulses: [0]=left [1]=right [2]=jump [3]=slide
//   frame_tick        one-cycle pulse per game frame
//   run_en            game running; low flushes the FIFO and freezes the player
//   lane              current lane, 0..LANES-1
//   pose              0=RUN 1=JUMP 2=SLIDE
//   height            jump height (triangle, peak JUMP_FRAMES/2), 0 unless JUMP
//   busy              pose != RUN
//   cmd_cnt           FIFO occupancy
//   drop_cnt          saturating dropped-command count
//
// Optional feature macro: CMD_DROP_COUNT_EN (enables drop_cnt; otherwise drop_cnt is tied to 0).
module runner_cmd_ctrl #(
  parameter int LANES        = 3,
  parameter int CMD_DEPTH    = 2,
  parameter int JUMP_FRAMES  = 24,
  parameter int SLIDE_FRAMES = 20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [3:0]                   btn,
  input  logic                         frame_tick,
  input  logic                         run_en,
  output logic [$clog2(LANES)-1:0]     lane,
  output logic [1:0]                   pose,
  output logic [7:0]                   height,
  output logic                         busy,
  output logic [$clog2(CMD_DEPTH):0]   cmd_cnt,
  output logic [7:0]                   drop_cnt
);

  localparam int LW = $clog2(LANES);
  localparam int PW = $clog2(CMD_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [LW-1:0] LANE_MAX  = LW'(LANES - 1);
  localparam logic [LW-1:0] LANE_MID  = LW'((LANES - 1) / 2);
  localparam logic [CW-1:0] FULL_CNT  = CW'(CMD_DEPTH);
  localparam logic [7:0]    JUMP_LEN  = 8'(JUMP_FRAMES);
  localparam logic [7:0]    JUMP_HALF = 8'(JUMP_FRAMES / 2);
  localparam logic [7:0]    SLIDE_LEN = 8'(SLIDE_FRAMES);

  localparam logic [1:0] CMD_LEFT  = 2'd0;
  localparam logic [1:0] CMD_RIGHT = 2'd1;
  localparam logic [1:0] CMD_JUMP  = 2'd2;
  localparam logic [1:0] CMD_SLIDE = 2'd3;

  typedef enum logic [1:0] {
    POSE_RUN   = 2'd0,
    POSE_JUMP  = 2'd1,
    POSE_SLIDE = 2'd2
  } pose_e;

  // ---------------------------------------------------------------
  // Command encode: one command per pulse cycle, jump > slide > left > right
  // ---------------------------------------------------------------
  logic [1:0] push_cmd;
  logic       push_req;

  always_comb begin
    push_cmd = CMD_RIGHT;
    if (btn[2])      push_cmd = CMD_JUMP;
    else if (btn[3]) push_cmd = CMD_SLIDE;
    else if (btn[0]) push_cmd = CMD_LEFT;
  end

  assign push_req = run_en && (btn != 4'd0);

  // ---------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------
  logic [1:0]    mem [CMD_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;

  pose_e      pose_q, pose_nxt;
  logic [7:0] timer_q, timer_nxt;
  logic [LW-1:0] lane_q, lane_nxt;

  logic       tick_en;
  logic [1:0] head;
  logic       head_vld;
  logic       head_is_lane;
  logic       full;
  logic       pop;
  logic       push_ok;

  assign tick_en      = frame_tick && run_en;
  assign head         = mem[rd_ptr];
  assign head_vld     = (cnt != '0);
  assign head_is_lane = ~head[1];
  assign full         = (cnt == FULL_CNT);
  // Jump/slide at the head waits until the player is back to RUN;
  // lane commands are always consumed.
  assign pop          = tick_en && head_vld && ((pose_q == POSE_RUN) || head_is_lane);
  // A full FIFO still accepts a push when a pop frees a slot the same cycle.
  assign push_ok      = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_cmd;
  end

  always_ff @(posedge clk) begin
    if (rst || !run_en) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push_ok) cnt <= cnt - 1'b1;
    end
  end

  assign cmd_cnt = cnt;

  // ---------------------------------------------------------------
  // Player FSM: state register
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pose_q  <= POSE_RUN;
      timer_q <= 8'd0;
      lane_q  <= LANE_MID;
    end else begin
      pose_q  <= pose_nxt;
      timer_q <= timer_nxt;
      lane_q  <= lane_nxt;
    end
  end

  // ---------------------------------------------------------------
  // Player FSM: next state
  // ---------------------------------------------------------------
  always_comb begin
    pose_nxt  = pose_q;
    timer_nxt = timer_q;
    lane_nxt  = lane_q;

    // Lane moves apply in any pose, saturating at the edges.
    if (pop && head == CMD_LEFT && lane_q != '0)
      lane_nxt = lane_q - 1'b1;
    else if (pop && head == CMD_RIGHT && lane_q != LANE_MAX)
      lane_nxt = lane_q + 1'b1;

    case (pose_q)
      POSE_RUN: begin
        if (pop && head == CMD_JUMP) begin
          pose_nxt  = POSE_JUMP;
          timer_nxt = JUMP_LEN;
        end else if (pop && head == CMD_SLIDE) begin
          pose_nxt  = POSE_SLIDE;
          timer_nxt = SLIDE_LEN;
        end
      end
      POSE_JUMP, POSE_SLIDE: begin
        if (tick_en) begin
          if (timer_q <= 8'd1) begin
            pose_nxt  = POSE_RUN;
            timer_nxt = 8'd0;
          end else begin
            timer_nxt = timer_q - 8'd1;
          end
        end
      end
      default: begin
        pose_nxt  = POSE_RUN;
        timer_nxt = 8'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------
  // Player FSM: outputs
  // ---------------------------------------------------------------
  logic [7:0] elapsed;

  always_comb begin
    elapsed = JUMP_LEN - timer_q;
    height  = 8'd0;
    if (pose_q == POSE_JUMP) begin
      // Rising half while elapsed <= peak, then mirror back down.
      if (elapsed <= JUMP_HALF) height = elapsed;
      else                      height = JUMP_LEN - elapsed;
    end
    busy = (pose_q != POSE_RUN);
  end

  assign pose = pose_q;
  assign lane = lane_q;

  // ---------------------------------------------------------------
  // Dropped-command counter
  // ---------------------------------------------------------------
`ifdef CMD_DROP_COUNT_EN
  logic       drop;
  logic [7:0] drop_q;

  assign drop = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (rst)                           drop_q <= 8'd0;
    else if (drop && drop_q != 8'hFF)  drop_q <= drop_q + 8'd1;
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_runner_cmd_ctrl.sv
// Directed bench for runner_cmd_ctrl with default parameters
// (LANES=3, CMD_DEPTH=2, JUMP_FRAMES=24, SLIDE_FRAMES=20).
module tb_runner_cmd_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] btn;
  logic       frame_tick;
  logic       run_en;
  logic [1:0] lane;
  logic [1:0] pose;
  logic [7:0] height;
  logic       busy;
  logic [1:0] cmd_cnt;
  logic [7:0] drop_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int exp_h;

`ifdef CMD_DROP_COUNT_EN
  localparam int EXP_DROP = 3;
`else
  localparam int EXP_DROP = 0;
`endif

  runner_cmd_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .btn        (btn),
    .frame_tick (frame_tick),
    .run_en     (run_en),
    .lane       (lane),
    .pose       (pose),
    .height     (height),
    .busy       (busy),
    .cmd_cnt    (cmd_cnt),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] b);
    btn = b;
    cyc();
    btn = 4'd0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  initial begin
    rst = 1'b1; btn = 4'd0; frame_tick = 1'b0; run_en = 1'b1;
    cyc(); cyc();
    rst = 1'b0;

    // Reset state
    check("rst_lane", lane, 1);
    check("rst_pose", pose, 0);
    check("rst_height", height, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt", cmd_cnt, 0);
    check("rst_drop", drop_cnt, 0);

    // Left moves 1 -> 0, second left saturates
    pulse(4'b0001);
    check("left_queued", cmd_cnt, 1);
    check("left_not_yet", lane, 1);
    tick();
    check("left_lane", lane, 0);
    check("left_cnt", cmd_cnt, 0);
    pulse(4'b0001);
    tick();
    check("left_sat_lane", lane, 0);
    check("left_sat_cnt", cmd_cnt, 0);
    pulse(4'b0010);
    tick();
    check("right_lane", lane, 1);

    // Full jump: triangle height, back to RUN after 24 ticks
    pulse(4'b0100);
    tick();
    check("jump_pose", pose, 1);
    check("jump_h0", height, 0);
    check("jump_busy", busy, 1);
    for (int k = 1; k <= 23; k++) begin
      tick();
      exp_h = (k <= 12) ? k : 24 - k;
      check("jump_h", height, exp_h);
      check("jump_still", pose, 1);
    end
    tick();
    check("jump_end_pose", pose, 0);
    check("jump_end_h", height, 0);
    check("jump_end_busy", busy, 0);

    // Lane change mid-air, slide blocked until after landing
    pulse(4'b0100);
    tick();
    pulse(4'b0010);
    pulse(4'b1000);
    check("air_cnt2", cmd_cnt, 2);
    tick();
    check("air_lane", lane, 2);
    check("air_pose", pose, 1);
    check("air_cnt1", cmd_cnt, 1);
    check("air_h", height, 1);
    for (int k = 0; k < 22; k++) tick();
    check("air_last_pose", pose, 1);
    check("air_last_h", height, 1);
    tick();
    check("land_pose", pose, 0);
    check("land_cnt", cmd_cnt, 1);
    tick();
    check("slide_pose", pose, 2);
    check("slide_cnt", cmd_cnt, 0);
    check("slide_h", height, 0);
    check("slide_busy", busy, 1);
    for (int k = 0; k < 19; k++) tick();
    check("slide_last", pose, 2);
    tick();
    check("slide_end", pose, 0);

    // Full FIFO drops, then push coincident with pop
    pulse(4'b0001);
    pulse(4'b0010);
    check("full_cnt", cmd_cnt, 2);
    pulse(4'b0100);
    pulse(4'b1000);
    pulse(4'b0001);
    check("drop_cnt_full", cmd_cnt, 2);
    check("drop_cnt", drop_cnt, EXP_DROP);
    btn = 4'b0100; frame_tick = 1'b1;
    cyc();
    btn = 4'd0; frame_tick = 1'b0;
    check("pushpop_cnt", cmd_cnt, 2);
    check("pushpop_drop", drop_cnt, EXP_DROP);
    check("pushpop_lane", lane, 1);
    run_en = 1'b0;
    cyc();
    run_en = 1'b1;
    check("flush_cnt", cmd_cnt, 0);
    check("flush_lane", lane, 1);

    // All buttons at once: exactly one jump
    pulse(4'b1111);
    check("multi_cnt", cmd_cnt, 1);
    tick();
    check("multi_pose", pose, 1);
    check("multi_lane", lane, 1);
    for (int k = 0; k < 24; k++) tick();
    check("multi_end", pose, 0);

    // Pause mid-slide with a queued command
    pulse(4'b1000);
    tick();
    for (int k = 0; k < 5; k++) tick();
    pulse(4'b0001);
    check("pause_q", cmd_cnt, 1);
    run_en = 1'b0;
    cyc();
    check("pause_flush", cmd_cnt, 0);
    for (int k = 0; k < 5; k++) begin
      btn = 4'b0010;
      tick();
    end
    btn = 4'd0;
    check("pause_ign", cmd_cnt, 0);
    check("pause_pose", pose, 2);
    check("pause_lane", lane, 1);
    run_en = 1'b1;
    cyc();
    for (int k = 0; k < 14; k++) tick();
    check("resume_last", pose, 2);
    tick();
    check("resume_end", pose, 0);
    check("resume_lane", lane, 1);

    // Reset in the middle of a jump
    pulse(4'b0100);
    tick();
    for (int k = 0; k < 3; k++) tick();
    check("mid_h", height, 3);
    pulse(4'b0010);
    tick();
    check("mid_lane", lane, 2);
    check("mid_h4", height, 4);
    pulse(4'b0001);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rst2_lane", lane, 1);
    check("rst2_pose", pose, 0);
    check("rst2_height", height, 0);
    check("rst2_busy", busy, 0);
    check("rst2_cnt", cmd_cnt, 0);
    check("rst2_drop", drop_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
